gate_truth_checker: RTL and testbench
=====================================

Name: gate_truth_checker

Overview:
Self-checking stimulus/response stage for small combinational gates, such as the mux-built AND/OR/XOR cells.
- Upstream: drives the gate under test (GUT) inputs through every input vector in ascending order.
- Downstream: waits a settle time, samples the GUT output and compares it against a parameterised truth table.
- Reports pass/fail, mismatch count and the first failing vector.
- Replaces hand-written per-gate initial-block benches with one reusable synthesizable checker.

Parameters:
N_IN, 2, number of GUT inputs (1..4).
SETTLE_CYCLES, 2, clock cycles between applying a vector and sampling (>=1).
EXPECTED, 4'b1110, expected GUT output per vector; bit i = output for gate_in==i; width 2**N_IN; default = OR.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  level; sampled only in IDLE; begins a sweep.
gate_in  out  N_IN  registered vector driven to the GUT inputs.
gate_out  in  1  GUT output (combinational from gate_in).
busy  out  1  high from the cycle after start is accepted through the last SAMPLE.
done  out  1  one-cycle pulse when the sweep completes.
pass  out  1  high if err_count==0 at completion; held until the next start.
err_count  out  N_IN+1  number of mismatching vectors; saturates impossible (max 2**N_IN fits).
first_fail_vec  out  N_IN  first vector that mismatched.
first_fail_valid  out  1  first_fail_vec is meaningful.

Behaviour:
- Reset (async, rst_n=0), all outputs 0: gate_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid; state=IDLE; vec=0; settle_cnt=0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 at an edge -> gate_in<=0, vec<=0, settle_cnt<=0, err_count<=0, first_fail_valid<=0, pass<=0, busy<=1, state<=SETTLE.
  - start=0 -> hold all outputs, including the previous pass/err results.
- SETTLE: settle_cnt increments each cycle. When settle_cnt==SETTLE_CYCLES-1, clear settle_cnt and go to SAMPLE. Occupies exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): compare gate_out with EXPECTED[vec].
  - On mismatch: err_count+1.
  - On mismatch with first_fail_valid==0: first_fail_vec<=vec, first_fail_valid<=1.
  - If vec==2**N_IN-1 -> state<=DONE, busy<=0.
  - Else vec<=vec+1, gate_in<=vec+1, state<=SETTLE.
- DONE (1 cycle): done=1; pass<=(err_count==0), using the count including the final sample; state<=IDLE.
- Timing: done is high in the cycle beginning 2**N_IN*(SETTLE_CYCLES+1)+1 edges after the edge that accepted start. Default = 13.
- gate_in changes only on SAMPLE->SETTLE transitions and on start acceptance; it is stable throughout each SETTLE/SAMPLE window.
- start while busy or in DONE: ignored, with no restart and no queueing.
- start held high continuously: a new sweep begins on the IDLE edge after DONE.
- Reset mid-sweep: immediate return to the reset values; partial results are discarded.
- vec does not wrap; the sweep terminates at the all-ones vector.

Optional Feature:
Macro GTC_OBS_TABLE_EN.
- Defined: adds output port obs_table [2**N_IN-1:0].
  - Cleared on start acceptance.
  - In SAMPLE, bit vec <= gate_out, giving the captured truth table of the GUT.
  - Valid when done=1; held until the next start. Reset value 0.
- Undefined: port and register absent; all other behaviour identical.

Decomposition:
- Shared package gtc_pkg:
  - State encoding localparams: IDLE=0, SETTLE=1, SAMPLE=2, DONE=3; 2-bit state width.
  - Default truth-table constants: TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110, TT_NAND2=4'b0111.
- One sub-module, gtc_settle_timer: counter with load/clear and a terminal-count flag at SETTLE_CYCLES-1. Same clock and asynchronous active-low reset.

Test Plan:
- Default parameters with the mux-based OR gate as GUT; pulse start -> gate_in sequence 0,1,2,3, each held 3 cycles; done at edge 13; pass=1, err_count=0, first_fail_valid=0.
- EXPECTED=TT_OR2 with an AND gate as GUT -> err_count=2, first_fail_vec=1, first_fail_valid=1, pass=0.
- GUT output tied to 1, EXPECTED=TT_OR2 -> err_count=1, first_fail_vec=0, pass=0; with GTC_OBS_TABLE_EN defined, obs_table=4'b1111.
- Pulse start again at edges 3 and 7 while busy -> ignored; exactly one done pulse at edge 13; a second start after done restarts cleanly with err_count reset to 0.
- Deassert rst_n at edge 6 of a sweep -> gate_in, busy, err_count and done are 0 immediately (asynchronous); after release, start gives a normal full sweep.
- N_IN=3, SETTLE_CYCLES=1, EXPECTED=8'b1000_0000 (AND3) with a 3-input AND GUT -> 8 vectors, 2 cycles each; done at edge 17; pass=1.

Source files
------------

// File: rtl/gtc_pkg.sv
// gtc_pkg: shared state encoding and common 2-input truth tables for gate_truth_checker
package gtc_pkg;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } gtc_state_t;

    // Bit i is the gate output for input vector i.
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
endpackage

// File: rtl/gtc_settle_timer.sv
// gtc_settle_timer: settle-window counter with clear and terminal-count flag
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the count to zero
//   en         : count this cycle; wraps to zero after the terminal count
//   tc         : count has reached SETTLE_CYCLES-1
module gtc_settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;

    logic [W-1:0] cnt;

    assign tc = cnt == W'(SETTLE_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: sweeps every input vector of a small gate and checks its output against a truth table
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin a sweep (accepted only while idle)
//   gate_in           : registered vector driven to the gate under test
//   gate_out          : gate under test output
//   busy              : sweep in progress
//   done              : one-cycle pulse when results are final
//   pass              : no mismatches in the last sweep
//   err_count         : number of mismatching vectors
//   first_fail_vec    : first mismatching vector, valid when first_fail_valid
//   obs_table         : captured truth table (only when GTC_OBS_TABLE_EN is defined)
module gate_truth_checker
    import gtc_pkg::*;
#(
    parameter int                  N_IN          = 2,
    parameter int                  SETTLE_CYCLES = 2,
    parameter logic [2**N_IN-1:0]  EXPECTED      = TT_OR2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N_IN-1:0]   gate_in,
    input  logic              gate_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_vec,
`ifdef GTC_OBS_TABLE_EN
    output logic [2**N_IN-1:0] obs_table,
`endif
    output logic              first_fail_valid
);
    gtc_state_t      state, state_nx;
    logic [N_IN-1:0] vec;
    logic            accept, tc, last, mis;

    assign accept  = state == IDLE && start;
    assign last    = &vec;
    assign mis     = gate_out != EXPECTED[vec];
    // vec is only ever loaded together with the GUT drive, so it is the drive.
    assign gate_in = vec;

    gtc_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == SETTLE),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SETTLE : IDLE;
            SETTLE:  state_nx = tc ? SAMPLE : SETTLE;
            SAMPLE:  state_nx = last ? DONE : SETTLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
`ifdef GTC_OBS_TABLE_EN
            obs_table        <= '0;
`endif
        end else begin
            // The pulse lands alongside pass, so both are seen together.
            done <= state == DONE;
            if (accept) begin
                vec              <= '0;
                err_count        <= '0;
                first_fail_valid <= 1'b0;
                pass             <= 1'b0;
                busy             <= 1'b1;
`ifdef GTC_OBS_TABLE_EN
                obs_table        <= '0;
`endif
            end
            if (state == SAMPLE) begin
                if (mis) begin
                    err_count <= err_count + 1'b1;
                    if (!first_fail_valid) begin
                        first_fail_vec   <= vec;
                        first_fail_valid <= 1'b1;
                    end
                end
                if (last)
                    busy <= 1'b0;
                else
                    vec <= vec + 1'b1;
`ifdef GTC_OBS_TABLE_EN
                obs_table[vec] <= gate_out;
`endif
            end
            if (state == DONE)
                pass <= err_count == '0;
        end
    end
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: directed bench for gate_truth_checker (2-input and 3-input instances)
module tb_gate_truth_checker;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] gate_in;
    logic       gate_out, busy, done, pass, first_fail_valid;
    logic [2:0] err_count;
    logic [1:0] first_fail_vec;
    logic [2:0] gate_in3;
    logic       busy3, done3, pass3, ffv3;
    logic [3:0] err3;
    logic [2:0] ffvec3;
`ifdef GTC_OBS_TABLE_EN
    logic [3:0] obs_table;
    logic [7:0] obs3;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int edges, dones;
    logic [1:0] gi [0:127];
    logic [2:0] ec [0:127];
    logic       bz [0:127];

    always #5 clk = ~clk;

    // GUT models: 0 = OR, 1 = AND, 2 = stuck at 1
    always_comb gate_out = mode == 2'd0 ? |gate_in : mode == 2'd1 ? &gate_in : 1'b1;

    gate_truth_checker dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .gate_in          (gate_in),
        .gate_out         (gate_out),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_vec   (first_fail_vec),
`ifdef GTC_OBS_TABLE_EN
        .obs_table        (obs_table),
`endif
        .first_fail_valid (first_fail_valid)
    );

    gate_truth_checker #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'b1000_0000)) dut3 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start3),
        .gate_in          (gate_in3),
        .gate_out         (&gate_in3),
        .busy             (busy3),
        .done             (done3),
        .pass             (pass3),
        .err_count        (err3),
        .first_fail_vec   (ffvec3),
`ifdef GTC_OBS_TABLE_EN
        .obs_table        (obs3),
`endif
        .first_fail_valid (ffv3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one sweep on dut; edges counts rising edges after the accepting edge until done is seen.
    task automatic sweep(input bit glitch, output int n_edges, output int n_dones);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_edges = 0;
        n_dones = 0;
        while (n_edges < 100) begin
            @(negedge clk);
            gi[n_edges] = gate_in;
            ec[n_edges] = err_count;
            bz[n_edges] = busy;
            if (done) begin
                n_dones++;
                break;
            end
            @(posedge clk);
            n_edges++;
            #1 start = glitch && (n_edges == 2 || n_edges == 6);
        end
        repeat (4) begin
            @(negedge clk);
            if (done) n_dones++;
        end
    endtask

    initial begin
        #12;
        check("rst_gate_in", gate_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_ffvalid", first_fail_valid, 0);
        @(negedge clk) rst_n = 1'b1;

        // OR gate against the OR table
        mode = 2'd0;
        sweep(1'b0, edges, dones);
        check("or_done_edge", edges, 13);
        check("or_gi_0", gi[0], 0);
        check("or_gi_2", gi[2], 0);
        check("or_gi_3", gi[3], 1);
        check("or_gi_6", gi[6], 2);
        check("or_gi_11", gi[11], 3);
        check("or_busy_0", bz[0], 1);
        check("or_busy_11", bz[11], 1);
        check("or_busy_12", bz[12], 0);
        check("or_pass", pass, 1);
        check("or_err", err_count, 0);
        check("or_ffvalid", first_fail_valid, 0);
        check("or_dones", dones, 1);
`ifdef GTC_OBS_TABLE_EN
        check("or_obs", obs_table, 4'b1110);
`endif

        // AND gate against the OR table, with start pulses while busy
        mode = 2'd1;
        sweep(1'b1, edges, dones);
        check("and_done_edge", edges, 13);
        check("and_err", err_count, 2);
        check("and_ffvec", first_fail_vec, 1);
        check("and_ffvalid", first_fail_valid, 1);
        check("and_pass", pass, 0);
        check("and_dones", dones, 1);
        check("and_idle_busy", busy, 0);
`ifdef GTC_OBS_TABLE_EN
        check("and_obs", obs_table, 4'b1000);
`endif

        // Restart after a failing sweep clears the results
        mode = 2'd0;
        sweep(1'b0, edges, dones);
        check("re_err_at_start", ec[0], 0);
        check("re_err", err_count, 0);
        check("re_pass", pass, 1);
        check("re_ffvalid", first_fail_valid, 0);

        // Stuck-at-1 output against the OR table
        mode = 2'd2;
        sweep(1'b0, edges, dones);
        check("one_err", err_count, 1);
        check("one_ffvec", first_fail_vec, 0);
        check("one_ffvalid", first_fail_valid, 1);
        check("one_pass", pass, 0);
`ifdef GTC_OBS_TABLE_EN
        check("one_obs", obs_table, 4'b1111);
`endif

        // Asynchronous reset mid-sweep (err_count is 1 by then with the AND gate)
        mode = 2'd1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_err", err_count, 1);
        check("pre_rst_gate_in", gate_in, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_gate_in", gate_in, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err_count, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk) rst_n = 1'b1;
        mode = 2'd0;
        sweep(1'b0, edges, dones);
        check("post_rst_done_edge", edges, 13);
        check("post_rst_pass", pass, 1);

        // 3-input AND, one settle cycle
        @(negedge clk) start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        edges = 0;
        while (edges < 100) begin
            @(negedge clk);
            if (done3) break;
            @(posedge clk);
            edges++;
        end
        check("and3_done_edge", edges, 17);
        check("and3_pass", pass3, 1);
        check("and3_err", err3, 0);
        check("and3_gate_in", gate_in3, 7);
`ifdef GTC_OBS_TABLE_EN
        check("and3_obs", obs3, 8'b1000_0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
